// File: rtl/transform_tree_walker.sv
// transform_tree_walker
// ---------------------
// Accepts one coding-unit (CU) descriptor at a time and walks its two-level
// transform quadtree in z-order. It emits one transform-unit (TU) descriptor
// per handshake to the inverse-transform engine.
//
// Oversize CUs and quadrants are split implicitly. Splits that would produce
// a TU below the minimum size are suppressed.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cu_valid/ready    CU descriptor handshake (ready only while idle)
//   cu_log2_size      CU size as log2
//   cu_split_flags    bit0 splits the root, bit(1+i) splits quadrant i
//   tu_valid/ready    TU descriptor handshake
//   tu_log2_size      TU size as log2
//   tu_size_code      tu_log2_size - 2
//   tu_x, tu_y        TU offset within the CU, in pixels
//   tu_last           final TU of the current CU
//   err               sticky flag for an illegal CU size
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. A producer holding valid keeps its payload stable and does not
// drop valid until that transfer. Ready may toggle freely.
module transform_tree_walker #(
    parameter int LOG2_MAX_CU = 6,
    parameter int LOG2_MAX_TU = 5,
    parameter int LOG2_MIN_TU = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cu_valid,
    output logic                   cu_ready,
    input  logic [2:0]             cu_log2_size,
    input  logic [4:0]             cu_split_flags,
    output logic                   tu_valid,
    input  logic                   tu_ready,
    output logic [2:0]             tu_log2_size,
    output logic [1:0]             tu_size_code,
    output logic [LOG2_MAX_CU-1:0] tu_x,
    output logic [LOG2_MAX_CU-1:0] tu_y,
    output logic                   tu_last,
    output logic                   err
);

    localparam int W = LOG2_MAX_CU;

    generate
        if ((LOG2_MAX_CU - LOG2_MAX_TU) < 0 || (LOG2_MAX_CU - LOG2_MAX_TU) > 2) begin : g_bad_cfg
            $error("transform_tree_walker: LOG2_MAX_CU - LOG2_MAX_TU must be 0..2");
        end
    endgenerate

    // Size thresholds kept at port width so every comparison is 3-bit.
    // "L-1 >= MIN" is written as "L > MIN" to avoid unsigned underflow.
    localparam logic [2:0] MAX_CU_L  = 3'(LOG2_MAX_CU);
    localparam logic [2:0] MAX_TU_L  = 3'(LOG2_MAX_TU);
    localparam logic [2:0] MAX_TU_P1 = 3'(LOG2_MAX_TU + 1);
    localparam logic [2:0] MIN_L     = 3'(LOG2_MIN_TU);
    localparam logic [2:0] MIN_P1    = 3'(LOG2_MIN_TU + 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0]   size;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         last;
    } tu_desc_t;

    // TU descriptor for traversal position (q0, q1) of a CU of size l
    function automatic tu_desc_t tu_at(input logic [2:0] l, input logic s0,
                                       input logic [3:0] s1, input logic [1:0] q0,
                                       input logic [1:0] q1);
        tu_desc_t     d;
        logic [W-1:0] qx, qy, rx, ry;
        qx     = W'(q0[0]) << (l - 3'd1);
        qy     = W'(q0[1]) << (l - 3'd1);
        rx     = W'(q1[0]) << (l - 3'd2);
        ry     = W'(q1[1]) << (l - 3'd2);
        d.size = l;
        d.x    = '0;
        d.y    = '0;
        d.last = 1'b1;
        if (s0) begin
            d.last = (q0 == 2'd3) && (!s1[3] || (q1 == 2'd3));
            if (s1[q0]) begin
                d.size = l - 3'd2;
                d.x    = qx + rx;
                d.y    = qy + ry;
            end else begin
                d.size = l - 3'd1;
                d.x    = qx;
                d.y    = qy;
            end
        end
        return d;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] l_q, l_d;
    logic       s0_q, s0_d;
    logic [3:0] s1_q, s1_d;
    logic [1:0] q0_q, q0_d;
    logic [1:0] q1_q, q1_d;
    tu_desc_t   tu_q, tu_d;
    logic [1:0] code_q, code_d;
    logic       tu_valid_q, tu_valid_d;
    logic       err_q, err_d;

    // Accept-side decode
    logic       cu_legal;
    logic       acc_s0;
    logic [3:0] acc_s1;
    // Advance-side counters
    logic [1:0] q0_nx, q1_nx;
    logic [2:0] code_full;

    always_comb begin
        cu_legal = !(cu_log2_size > MAX_CU_L) && !(cu_log2_size < MIN_L);
        acc_s0   = (cu_split_flags[0] || (cu_log2_size > MAX_TU_L)) && (cu_log2_size > MIN_L);
        for (int i = 0; i < 4; i++) begin
            acc_s1[i] = acc_s0 && (cu_split_flags[1+i] || (cu_log2_size > MAX_TU_P1))
                        && (cu_log2_size > MIN_P1);
        end

        // Leaf TU: q0 steps. Sub-split quadrant: q1 steps, carrying into q0.
        q0_nx = q0_q;
        q1_nx = q1_q;
        if (s1_q[q0_q]) begin
            q1_nx = q1_q + 2'd1;
            if (q1_q == 2'd3) begin
                q0_nx = q0_q + 2'd1;
            end
        end else begin
            q0_nx = q0_q + 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        q0_d       = q0_q;
        q1_d       = q1_q;
        tu_d       = tu_q;
        tu_valid_d = tu_valid_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (cu_valid) begin
                    if (!cu_legal) begin
                        err_d = 1'b1;
                    end else begin
                        l_d        = cu_log2_size;
                        s0_d       = acc_s0;
                        s1_d       = acc_s1;
                        q0_d       = 2'd0;
                        q1_d       = 2'd0;
                        tu_d       = tu_at(cu_log2_size, acc_s0, acc_s1, 2'd0, 2'd0);
                        tu_valid_d = 1'b1;
                        state_d    = EMIT;
                    end
                end
            end
            EMIT: begin
                if (tu_ready) begin
                    if (tu_q.last) begin
                        tu_d       = '0;
                        tu_valid_d = 1'b0;
                        q0_d       = 2'd0;
                        q1_d       = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        q0_d = q0_nx;
                        q1_d = q1_nx;
                        tu_d = tu_at(l_q, s0_q, s1_q, q0_nx, q1_nx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Code is registered alongside size so it resets to 0, not to 0-2
        code_full = tu_d.size - 3'd2;
        code_d    = tu_valid_d ? code_full[1:0] : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            l_q        <= '0;
            s0_q       <= 1'b0;
            s1_q       <= '0;
            q0_q       <= '0;
            q1_q       <= '0;
            tu_q       <= '0;
            code_q     <= '0;
            tu_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            tu_q       <= tu_d;
            code_q     <= code_d;
            tu_valid_q <= tu_valid_d;
            err_q      <= err_d;
        end
    end

    assign cu_ready     = (state_q == IDLE);
    assign tu_valid     = tu_valid_q;
    assign tu_log2_size = tu_q.size;
    assign tu_size_code = code_q;
    assign tu_x         = tu_q.x;
    assign tu_y         = tu_q.y;
    assign tu_last      = tu_q.last;
    assign err          = err_q;

endmodule

// File: doc/transform_tree_walker.md
# transform_tree_walker

Sequential successor to the combinational transform-size decision in the Inverse Quant & Transform path. It accepts one coding-unit (CU) descriptor at a time: CU size plus a 5-bit transform split-flag field. It walks the resulting two-level transform quadtree in z-order and emits one transform-unit (TU) descriptor per cycle to the inverse-transform engine. Behaviour added over the fixed selector:
- parametrised CU and TU size limits
- forced implicit splitting of oversize CUs
- TU position output
- valid/ready back-pressure

## Interface
Parameters:
- LOG2_MAX_CU, default 6: largest legal CU (64x64).
- LOG2_MAX_TU, default 5: largest TU (32x32). LOG2_MAX_CU - LOG2_MAX_TU must be 0..2; elaboration error otherwise.
- LOG2_MIN_TU, default 2: smallest TU (4x4).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- cu_valid, in, 1: CU descriptor valid.
- cu_ready, out, 1: block can accept a CU.
- cu_log2_size, in, 3: CU size as log2.
- cu_split_flags, in, 5: bit0 splits the root; bit(1+i) splits quadrant i.
- tu_valid, out, 1: TU descriptor valid.
- tu_ready, in, 1: consumer accepts the TU.
- tu_log2_size, out, 3: TU size as log2.
- tu_size_code, out, 2: tu_log2_size - 2 (0=4x4, 1=8x8, 2=16x16, 3=32x32).
- tu_x, out, LOG2_MAX_CU: TU x offset within the CU, in pixels.
- tu_y, out, LOG2_MAX_CU: TU y offset within the CU, in pixels.
- tu_last, out, 1: final TU of the current CU.
- err, out, 1: sticky flag for an illegal CU size. Cleared only by reset.

## Operation
FSM states are IDLE and EMIT.
- cu_ready = 1 only in IDLE.
- A CU is accepted on cu_valid & cu_ready.

On accept, let L = cu_log2_size.
- If L > LOG2_MAX_CU or L < LOG2_MIN_TU: set err, emit no TU, stay in IDLE.
- Otherwise register L and the effective split bits, then go to EMIT.
  - s0 = (flag0 | L > LOG2_MAX_TU) & (L-1 >= LOG2_MIN_TU).
  - s1[i] = s0 & (flag[1+i] | L-1 > LOG2_MAX_TU) & (L-2 >= LOG2_MIN_TU).

Traversal uses counters q0 and q1 (2 bits each), both 0 on entry.
- If !s0: emit a single TU of size L at (0,0) with tu_last=1.
- If s0 and !s1[q0]: emit size L-1 at x = q0[0]<<(L-1), y = q0[1]<<(L-1). Then q0 increments.
- If s0 and s1[q0]: emit size L-2 at x = (q0[0]<<(L-1)) + (q1[0]<<(L-2)), y likewise using bit 1. Then q1 increments; when q1 wraps from 3, q0 increments.
- tu_last = !s0, or q0==3 & (!s1[3] | q1==3).
- Counters advance only on tu_valid & tu_ready.
- Handshake of a tu_last TU returns the FSM to IDLE.

Sizes and offsets are unsigned. Offsets never exceed 2^L - 2^(L-2), so they fit in LOG2_MAX_CU bits without overflow.

## Timing
- Reset values: state IDLE, cu_ready=1, tu_valid=0, tu_last=0, tu_log2_size=0, tu_size_code=0, tu_x=0, tu_y=0, err=0, counters 0.
- All tu_* outputs are registered.
- First tu_valid appears the cycle after CU accept.
- Without stalls, one TU is emitted per cycle.
- cu_ready rises the cycle after the tu_last handshake. CU cost is therefore (#TU + 1) cycles.
- While tu_valid & !tu_ready, every tu_* output holds stable.
- tu_valid never drops without a handshake.
- cu_* inputs are ignored outside IDLE.
- An illegal-size CU costs one accept cycle; cu_ready stays 1.
- Asynchronous reset asserted mid-CU:
  - tu_valid goes to 0 immediately.
  - The partially walked CU is discarded.
  - cu_ready=1 from reset release onward.

## Test plan
1. Defaults; CU log2=5, flags=0 -> one TU: size 5, code 3, (0,0), tu_last=1. cu_ready returns 2 cycles after accept.
2. CU log2=6, flags=0 -> forced split into four TUs, each size 5: (0,0), (32,0), (0,32), (32,32). tu_last only on the 4th.
3. CU log2=4, flags=5'b00101 -> seven TUs in order:
   - 8x8 at (0,0)
   - 4x4 at (8,0), (12,0), (8,4), (12,4)
   - 8x8 at (0,8)
   - 8x8 at (8,8)
4. CU log2=3, flags=5'b11111 -> sub-splits are suppressed by LOG2_MIN_TU. Result is four TUs of size 2, code 0: (0,0), (4,0), (0,4), (4,4).
5. Case 3 with tu_ready held low for 3 cycles at the 2nd TU -> outputs hold (size 2, (8,0)), cu_ready stays 0, and the sequence then resumes unchanged.
6. Separate sub-tests:
   - CU log2=7 -> err=1, no tu_valid, cu_ready stays 1.
   - rst_n pulsed low during the 3rd TU of case 2 -> tu_valid=0 at once, err=0, and the next CU log2=5 produces the case-1 result.
